// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel/line counters with registered sync,
// active, coordinate and start-of-line/frame outputs, one pixel behind the counters.
module vga_timing_gen #(
    parameter int   H_ACTIVE = 640,
    parameter int   H_FP     = 16,
    parameter int   H_SYNC   = 96,
    parameter int   H_BP     = 48,
    parameter int   V_ACTIVE = 480,
    parameter int   V_FP     = 10,
    parameter int   V_SYNC   = 2,
    parameter int   V_BP     = 33,
    parameter logic HS_POL   = 1'b0,
    parameter logic VS_POL   = 1'b0,
    parameter int   CW       = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          pix_en,
    input  logic          run,
    output logic          hsync,
    output logic          vsync,
    output logic          active,
    output logic [CW-1:0] x,
    output logic [CW-1:0] y,
    output logic          line_start,
    output logic          frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CW-1:0] ZERO     = '0;
    localparam logic [CW-1:0] ONE      = CW'(1);
    localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_ACT_C  = CW'(H_ACTIVE);
    localparam logic [CW-1:0] V_ACT_C  = CW'(V_ACTIVE);
    localparam logic [CW-1:0] HS_START = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] HS_END   = CW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CW-1:0] VS_START = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] VS_END   = CW'(V_ACTIVE + V_FP + V_SYNC);

    logic [CW-1:0] hc_q, hc_d;
    logic [CW-1:0] vc_q, vc_d;
    logic          hsync_q, hsync_d;
    logic          vsync_q, vsync_d;
    logic          active_q, active_d;
    logic [CW-1:0] x_q, x_d;
    logic [CW-1:0] y_q, y_d;
    logic          line_start_q, line_start_d;
    logic          frame_start_q, frame_start_d;

    logic h_vis, v_vis, h_in_sync, v_in_sync;

    // Position decode of the counters as they stand before the coming edge.
    always_comb begin
        h_vis     = (hc_q < H_ACT_C);
        v_vis     = (vc_q < V_ACT_C);
        h_in_sync = (hc_q >= HS_START) && (hc_q < HS_END);
        v_in_sync = (vc_q >= VS_START) && (vc_q < VS_END);
    end

    // Next-state: hold without pix_en, idle/origin when stopped, else decode and advance.
    always_comb begin
        hc_d          = hc_q;
        vc_d          = vc_q;
        hsync_d       = hsync_q;
        vsync_d       = vsync_q;
        active_d      = active_q;
        x_d           = x_q;
        y_d           = y_q;
        line_start_d  = line_start_q;
        frame_start_d = frame_start_q;
        if (pix_en) begin
            if (!run) begin
                hc_d          = ZERO;
                vc_d          = ZERO;
                hsync_d       = ~HS_POL;
                vsync_d       = ~VS_POL;
                active_d      = 1'b0;
                x_d           = ZERO;
                y_d           = ZERO;
                line_start_d  = 1'b0;
                frame_start_d = 1'b0;
            end else begin
                hsync_d       = h_in_sync ? HS_POL : ~HS_POL;
                vsync_d       = v_in_sync ? VS_POL : ~VS_POL;
                active_d      = h_vis && v_vis;
                x_d           = (h_vis && v_vis) ? hc_q : ZERO;
                y_d           = (h_vis && v_vis) ? vc_q : ZERO;
                line_start_d  = (hc_q == ZERO);
                frame_start_d = (hc_q == ZERO) && (vc_q == ZERO);
                if (hc_q == H_LAST) begin
                    hc_d = ZERO;
                    vc_d = (vc_q == V_LAST) ? ZERO : (vc_q + ONE);
                end else begin
                    hc_d = hc_q + ONE;
                end
            end
        end
    end

    // State and output registers; reset forces the idle raster state at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hc_q          <= ZERO;
            vc_q          <= ZERO;
            hsync_q       <= ~HS_POL;
            vsync_q       <= ~VS_POL;
            active_q      <= 1'b0;
            x_q           <= ZERO;
            y_q           <= ZERO;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            hc_q          <= hc_d;
            vc_q          <= vc_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            active_q      <= active_d;
            x_q           <= x_d;
            y_q           <= y_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign active      = active_q;
    assign x           = x_q;
    assign y           = y_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: a tiny raster (8x5 totals, positive syncs)
// and a default 640x480 instance, both compared against position-based models.
module tb_vga_timing_gen;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic pix_en = 1'b0;
    logic run = 1'b0;

    logic       s_hs, s_vs, s_act, s_ls, s_fs;
    logic [9:0] s_x, s_y;
    logic       d_hs, d_vs, d_act, d_ls, d_fs;
    logic [9:0] d_x, d_y;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // model state: decoded position, whether the last decode was a running one, next position
    int e_pos   = 0;
    bit e_valid = 1'b0;
    int n_pos   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    vga_timing_gen #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1'b1), .VS_POL(1'b1), .CW(10)
    ) u_small (
        .clk(clk), .rst(rst), .pix_en(pix_en), .run(run),
        .hsync(s_hs), .vsync(s_vs), .active(s_act), .x(s_x), .y(s_y),
        .line_start(s_ls), .frame_start(s_fs)
    );

    vga_timing_gen u_def (
        .clk(clk), .rst(rst), .pix_en(pix_en), .run(run),
        .hsync(d_hs), .vsync(d_vs), .active(d_act), .x(d_x), .y(d_y),
        .line_start(d_ls), .frame_start(d_fs)
    );

    // {hsync, vsync, active, line_start, frame_start, x, y}
    function automatic logic [24:0] m_small(input int p, input bit v);
        int  h, l;
        bit  a;
        h = p % 8;
        l = (p / 8) % 5;
        if (!v) return 25'd0;
        a = (h < 4) && (l < 2);
        return {(h == 5 || h == 6), (l == 3), a, (h == 0), (h == 0 && l == 0),
                a ? 10'(h) : 10'd0, a ? 10'(l) : 10'd0};
    endfunction

    function automatic logic [24:0] m_def(input int p, input bit v);
        int  h, l;
        bit  a;
        h = p % 800;
        l = (p / 800) % 525;
        if (!v) return {2'b11, 23'd0};
        a = (h < 640) && (l < 480);
        return {!(h >= 656 && h < 752), !(l == 490 || l == 491), a, (h == 0),
                (h == 0 && l == 0), a ? 10'(h) : 10'd0, a ? 10'(l) : 10'd0};
    endfunction

    // One clock: update the model for this edge, then settle to the falling edge.
    task automatic advance();
        @(posedge clk);
        if (pix_en) begin
            if (run) begin
                e_pos   = n_pos;
                e_valid = 1'b1;
                n_pos   = n_pos + 1;
            end else begin
                e_valid = 1'b0;
                n_pos   = 0;
            end
        end
        @(negedge clk);
    endtask

    task automatic model_reset();
        e_valid = 1'b0;
        e_pos   = 0;
        n_pos   = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [24:0] gs, gd;
        rst = 1'b1; run = 1'b1; pix_en = 1'b1;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            gs = {s_hs, s_vs, s_act, s_ls, s_fs, s_x, s_y};
            gd = {d_hs, d_vs, d_act, d_ls, d_fs, d_x, d_y};
            n_tests++;
            if (gs !== 25'd0) begin
                n_fail++;
                $display("FAIL reset_small: got %h want %h", gs, 25'd0);
            end
            n_tests++;
            if (gd !== {2'b11, 23'd0}) begin
                n_fail++;
                $display("FAIL reset_def: got %h want %h", gd, {2'b11, 23'd0});
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_small_frame();
        logic [24:0] gs, gd;
        int last_fs, n_act, n_fs;
        do_reset();
        run = 1'b1; pix_en = 1'b1;
        last_fs = -1; n_act = 0; n_fs = 0;
        for (int i = 0; i < 81; i++) begin
            advance();
            gs = {s_hs, s_vs, s_act, s_ls, s_fs, s_x, s_y};
            gd = {d_hs, d_vs, d_act, d_ls, d_fs, d_x, d_y};
            n_tests++;
            if (gs !== m_small(e_pos, e_valid)) begin
                n_fail++;
                $display("FAIL small_frame pos %0d: got %h want %h", e_pos, gs, m_small(e_pos, e_valid));
            end
            n_tests++;
            if (gd !== m_def(e_pos, e_valid)) begin
                n_fail++;
                $display("FAIL def_frame pos %0d: got %h want %h", e_pos, gd, m_def(e_pos, e_valid));
            end
            if (i < 80 && s_act) n_act++;
            if (s_fs) begin
                n_fs++;
                if (last_fs >= 0) begin
                    n_tests++;
                    if (cyc - last_fs != 40) begin
                        n_fail++;
                        $display("FAIL small_frame_period: got %0d want 40", cyc - last_fs);
                    end
                end
                last_fs = cyc;
            end
        end
        n_tests++;
        if (n_act != 16) begin
            n_fail++;
            $display("FAIL small_active_count: got %0d want 16", n_act);
        end
        n_tests++;
        if (n_fs != 3) begin
            n_fail++;
            $display("FAIL small_frame_count: got %0d want 3", n_fs);
        end
    endtask

    task automatic test_pix_en_toggle();
        logic [24:0] gs, gd;
        int last_fs;
        do_reset();
        run = 1'b1;
        last_fs = -1;
        for (int i = 0; i < 162; i++) begin
            pix_en = (i % 2 == 0);
            advance();
            gs = {s_hs, s_vs, s_act, s_ls, s_fs, s_x, s_y};
            gd = {d_hs, d_vs, d_act, d_ls, d_fs, d_x, d_y};
            n_tests++;
            if (gs !== m_small(e_pos, e_valid)) begin
                n_fail++;
                $display("FAIL toggle_small cyc %0d: got %h want %h", i, gs, m_small(e_pos, e_valid));
            end
            n_tests++;
            if (gd !== m_def(e_pos, e_valid)) begin
                n_fail++;
                $display("FAIL toggle_def cyc %0d: got %h want %h", i, gd, m_def(e_pos, e_valid));
            end
            if (s_fs && pix_en) begin
                if (last_fs >= 0) begin
                    n_tests++;
                    if (cyc - last_fs != 80) begin
                        n_fail++;
                        $display("FAIL toggle_frame_period: got %0d want 80", cyc - last_fs);
                    end
                end
                last_fs = cyc;
            end
        end
        pix_en = 1'b1;
    endtask

    task automatic test_run_stop();
        logic [24:0] gs, gd;
        do_reset();
        run = 1'b1; pix_en = 1'b1;
        for (int i = 0; i < 24; i++) begin
            run = !(i >= 13 && i < 18);
            advance();
            gs = {s_hs, s_vs, s_act, s_ls, s_fs, s_x, s_y};
            gd = {d_hs, d_vs, d_act, d_ls, d_fs, d_x, d_y};
            n_tests++;
            if (gs !== m_small(e_pos, e_valid)) begin
                n_fail++;
                $display("FAIL run_small step %0d: got %h want %h", i, gs, m_small(e_pos, e_valid));
            end
            n_tests++;
            if (gd !== m_def(e_pos, e_valid)) begin
                n_fail++;
                $display("FAIL run_def step %0d: got %h want %h", i, gd, m_def(e_pos, e_valid));
            end
            if (i == 18) begin
                n_tests++;
                if (s_fs !== 1'b1 || s_x !== 10'd0 || s_y !== 10'd0 || s_act !== 1'b1) begin
                    n_fail++;
                    $display("FAIL run_restart: got fs=%b act=%b x=%0d y=%0d want fs=1 act=1 x=0 y=0",
                             s_fs, s_act, s_x, s_y);
                end
            end
        end
    endtask

    task automatic test_rst_midline();
        logic [24:0] gs, gd;
        do_reset();
        run = 1'b1; pix_en = 1'b1;
        for (int i = 0; i < 11; i++) advance();
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        gs = {s_hs, s_vs, s_act, s_ls, s_fs, s_x, s_y};
        gd = {d_hs, d_vs, d_act, d_ls, d_fs, d_x, d_y};
        n_tests++;
        if (gs !== 25'd0) begin
            n_fail++;
            $display("FAIL rst_mid_small: got %h want %h", gs, 25'd0);
        end
        n_tests++;
        if (gd !== {2'b11, 23'd0}) begin
            n_fail++;
            $display("FAIL rst_mid_def: got %h want %h", gd, {2'b11, 23'd0});
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            advance();
            gs = {s_hs, s_vs, s_act, s_ls, s_fs, s_x, s_y};
            n_tests++;
            if (gs !== m_small(e_pos, e_valid)) begin
                n_fail++;
                $display("FAIL rst_resume pos %0d: got %h want %h", e_pos, gs, m_small(e_pos, e_valid));
            end
        end
    endtask

    task automatic test_default_lines();
        logic [24:0] gd;
        int last_ls, hs_low;
        do_reset();
        run = 1'b1; pix_en = 1'b1;
        last_ls = -1; hs_low = 0;
        for (int i = 0; i < 1700; i++) begin
            advance();
            gd = {d_hs, d_vs, d_act, d_ls, d_fs, d_x, d_y};
            n_tests++;
            if (gd !== m_def(e_pos, e_valid)) begin
                n_fail++;
                $display("FAIL def_line pos %0d: got %h want %h", e_pos, gd, m_def(e_pos, e_valid));
            end
            if (i < 800 && !d_hs) hs_low++;
            if (d_ls) begin
                if (last_ls >= 0) begin
                    n_tests++;
                    if (cyc - last_ls != 800) begin
                        n_fail++;
                        $display("FAIL def_line_period: got %0d want 800", cyc - last_ls);
                    end
                end
                last_ls = cyc;
            end
        end
        n_tests++;
        if (hs_low != 96) begin
            n_fail++;
            $display("FAIL def_hsync_width: got %0d want 96", hs_low);
        end
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_small_frame();
        test_pix_en_toggle();
        test_run_stop();
        test_rst_midline();
        test_default_lines();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
